// File: rtl/tracker_policy.sv
// tracker_policy: N-sensor line-tracking policy engine.
// Debounces each raw sensor, reduces the debounced vector to a steering
// decision, coasts through short line losses, searches in the last known
// turn direction for a bounded time, then stops with a sticky fault.
module tracker_policy #(
    parameter int N_SENSORS       = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOST_CYCLES     = 20000000,
    parameter int SEARCH_CYCLES   = 40000000,
    parameter int CNT_W           = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic                 start_move,
    input  logic                 stop_req,
    output logic [1:0]           state,
    output logic [1:0]           pre_state,
    output logic                 searching,
    output logic                 fault,
    output logic [N_SENSORS-1:0] sensor_db
);

    localparam int C    = (N_SENSORS - 1) / 2;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST   = CNT_W'(LOST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_STOP,
        S_STRAIGHT,
        S_LEFT,
        S_RIGHT,
        S_SEARCH
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic             last_dir_q, last_dir_d;   // 0 = left, 1 = right
    logic [CNT_W-1:0] lost_q, lost_d;
    logic [CNT_W-1:0] search_q, search_d;
    logic             fault_d;
    logic [1:0]       state_d;
    logic [DB_W-1:0]  db_cnt [N_SENSORS];

    // Motor command code for an internal state; SEARCH reuses the turn codes.
    function automatic logic [1:0] encode(input fsm_t f, input logic dir);
        case (f)
            S_STRAIGHT: encode = 2'b11;
            S_LEFT:     encode = 2'b10;
            S_RIGHT:    encode = 2'b01;
            S_SEARCH:   encode = dir ? 2'b01 : 2'b10;
            default:    encode = 2'b00;
        endcase
    endfunction

    // Steering decision from the weight of sensors left and right of centre.
    function automatic fsm_t policy(input logic [N_SENSORS-1:0] s);
        int l;
        int r;
        l = 0;
        r = 0;
        for (int i = C + 1; i < N_SENSORS; i++) l = l + int'(s[i]);
        for (int i = 0; i < C; i++)             r = r + int'(s[i]);
        if (l > r)      policy = S_LEFT;
        else if (r > l) policy = S_RIGHT;
        else            policy = S_STRAIGHT;
    endfunction

    // Per-bit debounce: accept a change after DEBOUNCE_CYCLES mismatching edges.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            sensor_db <= '0;
            for (int i = 0; i < N_SENSORS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (sensor[i] != sensor_db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        sensor_db[i] <= sensor[i];
                        db_cnt[i]    <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Next-state, counter and fault logic for the motion FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        fsm_d    = fsm_q;
        lost_d   = lost_q;
        search_d = search_q;
        fault_d  = fault;

        if (stop_req) begin
            fsm_d    = S_STOP;
            lost_d   = '0;
            search_d = '0;
        end else begin
            case (fsm_q)
                S_STOP: begin
                    if (start_move && sensor_db != '0) begin
                        fsm_d   = S_STRAIGHT;
                        fault_d = 1'b0;
                    end
                end
                S_STRAIGHT, S_LEFT, S_RIGHT: begin
                    if (sensor_db != '0) begin
                        fsm_d  = policy(sensor_db);
                        lost_d = '0;
                    end else if (lost_q == LOST_LAST) begin
                        fsm_d  = S_SEARCH;
                        lost_d = '0;
                    end else begin
                        lost_d = lost_q + 1'b1;
                    end
                end
                S_SEARCH: begin
                    if (sensor_db != '0) begin
                        fsm_d    = policy(sensor_db);
                        search_d = '0;
                    end else if (search_q == SEARCH_LAST) begin
                        fsm_d    = S_STOP;
                        fault_d  = 1'b1;
                        search_d = '0;
                    end else begin
                        search_d = search_q + 1'b1;
                    end
                end
                default: fsm_d = S_STOP;
            endcase
        end

        case (fsm_d)
            S_LEFT:  last_dir_d = 1'b0;
            S_RIGHT: last_dir_d = 1'b1;
            default: last_dir_d = last_dir_q;
        endcase

        state_d = encode(fsm_d, last_dir_d);
    end

    // FSM, counters, direction memory and command history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= S_STOP;
            last_dir_q <= 1'b0;
            lost_q     <= '0;
            search_q   <= '0;
            fault      <= 1'b0;
            pre_state  <= 2'b00;
        end else begin
            fsm_q      <= fsm_d;
            last_dir_q <= last_dir_d;
            lost_q     <= lost_d;
            search_q   <= search_d;
            fault      <= fault_d;
            if (state_d != state) pre_state <= state;
        end
    end

    // Outputs decode registered state only; no input reaches them directly.
    assign state     = encode(fsm_q, last_dir_q);
    assign searching = (fsm_q == S_SEARCH);

endmodule

// File: doc/tracker_policy.md
# tracker_policy

Parametrised line-tracking policy engine for the car lab. It replaces the fixed three-sensor tracker policy and accepts N line sensors. Each sensor is debounced, the line position is reduced to a steering decision, and a lost-line timer drives a bounded search in the last known turn direction before a fault stop. It sits between the raw sensor pins and the motor controller, which consumes the same 2-bit `state` encoding as before.

## Interface
- `N_SENSORS`, 3: number of sensors; must be odd and ≥3. Bit N−1 is leftmost, bit 0 is rightmost, centre index C=(N−1)/2.
- `DEBOUNCE_CYCLES`, 4: consecutive samples needed to accept a sensor change; 1 disables filtering.
- `LOST_CYCLES`, 20000000: consecutive no-line cycles in motion before SEARCH.
- `SEARCH_CYCLES`, 40000000: maximum consecutive no-line cycles in SEARCH before fault stop.
- `CNT_W`, 26: width of the lost and search counters; must satisfy 2^CNT_W > max(LOST_CYCLES, SEARCH_CYCLES).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; all registers take their reset values on the next `clk` edge.
- `sensor` in N_SENSORS: raw tracker inputs; 1 = line detected.
- `start_move` in 1: level; permits leaving STOP.
- `stop_req` in 1: level; forces STOP.
- `state` out 2: motion command; 00 stop, 01 turn_right, 10 turn_left, 11 go_straight.
- `pre_state` out 2: value `state` held before its most recent change.
- `searching` out 1: high while in SEARCH.
- `fault` out 1: sticky; line not reacquired within the search window.
- `sensor_db` out N_SENSORS: debounced sensor vector.

## Operation
- Debounce, per bit i: a counter increments on each edge where `sensor[i]`≠`sensor_db[i]` and clears when they are equal. `sensor_db[i]` takes `sensor[i]` on the DEBOUNCE_CYCLES-th consecutive mismatching edge, and the counter then clears.
- Policy on s=`sensor_db`: L = popcount(s[N−1:C+1]), R = popcount(s[C−1:0]).
  - s==0: lost.
  - L>R: LEFT.
  - R>L: RIGHT.
  - Otherwise: STRAIGHT. This includes all-ones, centre-only, and symmetric patterns.
- Internal states are STOP, STRAIGHT, LEFT, RIGHT and SEARCH.
  - STOP → STRAIGHT when `start_move`=1 and s≠0. This transition also clears `fault`.
  - STRAIGHT, LEFT, RIGHT with s≠0: the next state is the policy result, and `lost_cnt` clears.
  - STRAIGHT, LEFT, RIGHT with s==0: the state holds (coast) and `lost_cnt` increments. On the edge where `lost_cnt`==LOST_CYCLES−1 the state goes to SEARCH and `lost_cnt` clears.
  - SEARCH with s≠0: the next state is the policy result, and `search_cnt` clears.
  - SEARCH with s==0: `search_cnt` increments. On the edge where `search_cnt`==SEARCH_CYCLES−1 the state goes to STOP, `fault`←1, and `search_cnt` clears.
- `last_dir` register (0 = left, 1 = right): updated on every edge where the next state is LEFT or RIGHT. Its reset value is 0.
- `state` encoding: SEARCH outputs 10 if `last_dir`=0, else 01. `searching` = (state==SEARCH).
- `pre_state` ← current `state` only on edges where the output `state` value changes. Entering SEARCH with an unchanged turn code does not update it.
- Priority: `reset` > `stop_req` > normal transitions.
  - `stop_req`=1: the state goes to STOP on the next edge and both counters clear. `fault` and `last_dir` are unchanged, and debounce keeps running.
  - In STOP, `start_move`=0 or `stop_req`=1 holds STOP.
- Counters never wrap, because the thresholds are reached first.

## Timing
- Reset values: `state`=00, `pre_state`=00, `searching`=0, `fault`=0, `sensor_db`=0, `last_dir`=0, all counters 0.
- Raw change held stable from edge k: `sensor_db` updates at edge k+DEBOUNCE_CYCLES−1, and `state` reflects it at edge k+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+1 edges, counting the sampling edge.
- A glitch shorter than DEBOUNCE_CYCLES edges never reaches `sensor_db` or `state`.
- SEARCH is entered exactly LOST_CYCLES edges after `sensor_db` first reads 0 in motion.
- A `reset` asserted mid-SEARCH or mid-debounce returns every output to its reset value on that edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
All scenarios use N_SENSORS=5, DEBOUNCE_CYCLES=4, LOST_CYCLES=16, SEARCH_CYCLES=32.

- **Reset/start:** hold `reset` 2 cycles, `sensor`=00100, `start_move`=1 → `state`=00 during reset; `sensor_db`=00100 4 edges after release; `state`=11 one edge later.
- **Debounce:** in STRAIGHT, pulse `sensor`=11000 for 3 cycles → `state` stays 11. Hold it for 4 cycles → `sensor_db`=11000, then `state`=10 and `pre_state`=11.
- **Right turn and tie:** `sensor`=00011 → `state`=01. Then `sensor`=10001 → `state`=11, `pre_state`=01.
- **Lost/search:** from RIGHT, `sensor`=00000 → `state` holds 01 for 15 edges after `sensor_db`=0. At the 16th edge `searching`=1 and `state`=01 with `pre_state` unchanged. Then `sensor`=00100 → `state`=11, `searching`=0.
- **Fault:** from LEFT, `sensor`=00000 → SEARCH after 16 edges, then STOP after 32 more edges, with `fault`=1 and `state`=00. Then `sensor`=00100 with `start_move`=1 → `fault`=0 and `state`=11.
- **Stop priority:** assert `stop_req` mid-SEARCH → `state`=00 and `searching`=0 next edge, `fault` unchanged. Assert `reset` mid-debounce → `sensor_db`=0 on that edge.
